// File: rtl/axi_apb_pkg.sv
// Shared definitions for the AXI-to-APB bridge: write-channel FSM states,
// default burst-length width and packed write-data word field positions.
package axi_apb_pkg;

    localparam int LEN_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DONE = 2'd2
    } wchan_state_e;

    // Packed FIFO word layout is {last, strb, data}; data occupies the LSBs.
    function automatic int word_strb_lsb(input int data_width);
        return data_width;
    endfunction

    function automatic int word_last_bit(input int data_width);
        return data_width + data_width / 8;
    endfunction

endpackage : axi_apb_pkg

// File: rtl/axi_wchan_rx.sv
// AXI write-data channel receiver: takes one burst command, then pushes exactly
// len+1 W beats into the write-data FIFO. Optional WLAST_CHECK_EN adds a sticky WLAST mismatch flag.
module axi_wchan_rx
    import axi_apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
    parameter int WORD_WIDTH = DATA_WIDTH + STRB_WIDTH + 1
) (
    input  logic                  wclk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [STRB_WIDTH-1:0] s_wstrb,
    input  logic                  s_wlast,
    output logic                  fifo_wr,
    output logic [WORD_WIDTH-1:0] fifo_data_in,
    input  logic                  fifo_full,
    output logic                  burst_done,
    output logic [LEN_WIDTH-1:0]  beat_cnt
`ifdef WLAST_CHECK_EN
    ,
    output logic                  wlast_err,
    input  logic                  err_clr
`endif
);

    wchan_state_e         state;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 beat;
    logic                 int_last;

    // NOTE: ready and the FIFO strobe are combinational so that a rising
    // fifo_full blocks the beat in the same cycle and the FIFO captures on the
    // same edge that completes the handshake; registering them would need a skid.
    assign s_wready     = (state == DATA) && !fifo_full;
    assign beat         = s_wvalid && s_wready;
    assign int_last     = (beat_cnt == len_q);
    assign fifo_wr      = beat;
    assign fifo_data_in = {int_last, s_wstrb, s_wdata};

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            burst_done <= 1'b0;
            beat_cnt   <= '0;
            len_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        len_q     <= cmd_len;
                        beat_cnt  <= '0;
                        cmd_ready <= 1'b0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        if (int_last) begin
                            burst_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    burst_done <= 1'b0;
                    cmd_ready  <= 1'b1;
                    beat_cnt   <= '0;
                    state      <= IDLE;
                end
                default: begin
                    burst_done <= 1'b0;
                    cmd_ready  <= 1'b1;
                    beat_cnt   <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef WLAST_CHECK_EN
    // A mismatch in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wlast_err <= 1'b0;
        end else if (beat && (s_wlast != int_last)) begin
            wlast_err <= 1'b1;
        end else if (err_clr) begin
            wlast_err <= 1'b0;
        end
    end
`else
    logic unused_wlast;
    assign unused_wlast = s_wlast;
`endif

endmodule : axi_wchan_rx
